// File: rtl/full_adder_32bit.sv
// Registered WIDTH-bit ripple-carry adder: {Cout, S} <= A + B + Cin, one cycle latency.
// The carry chain is a structural string of 1-bit full-adder cells feeding one output register.

module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    // Propagate term is shared by the sum and the carry-out.
    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module full_adder_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    assign w_carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .i_a (A[i]),
            .i_b (B[i]),
            .i_c (w_carry[i]),
            .o_s (w_sum[i]),
            .o_c (w_carry[i+1])
        );
    end

    // Reset drops any in-flight result; outputs read 0 until the first post-reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[WIDTH];
        end
    end

    assign S    = r_sum;
    assign Cout = r_cout;
endmodule

// File: tb/tb_full_adder_32bit.sv
// Bench for full_adder_32bit: directed and random vectors through a scoreboard queue,
// plus direct checks of asynchronous reset behaviour.

module tb_full_adder_32bit;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [W-1:0] S;
    logic         Cout;

    logic [W:0] exp_q[$];
    int n_checks;
    int n_pass;
    bit drive_done;

    full_adder_32bit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        return r;
    endfunction

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got Cout=%0b S=%08h expected Cout=%0b S=%08h",
                      name, got[W], got[W-1:0], want[W], want[W-1:0]);
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; the expected result is queued for the next rising edge.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W:0] want);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = c;
        exp_q.push_back(want);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() != 0) check("scoreboard", {Cout, S}, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] dir_a   [9];
    logic [W-1:0] dir_b   [9];
    logic         dir_c   [9];
    logic [W:0]   dir_exp [9];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        drive_done = 1'b0;

        dir_a[0] = 32'h0000_0000; dir_b[0] = 32'h0000_0000; dir_c[0] = 1'b0; dir_exp[0] = {1'b0, 32'h0000_0000};
        dir_a[1] = 32'h0000_0000; dir_b[1] = 32'h0000_0000; dir_c[1] = 1'b1; dir_exp[1] = {1'b0, 32'h0000_0001};
        dir_a[2] = 32'hFFFF_FFFF; dir_b[2] = 32'h0000_0001; dir_c[2] = 1'b0; dir_exp[2] = {1'b1, 32'h0000_0000};
        dir_a[3] = 32'hFFFF_FFFF; dir_b[3] = 32'h0000_0001; dir_c[3] = 1'b1; dir_exp[3] = {1'b1, 32'h0000_0001};
        dir_a[4] = 32'hFFFF_FFFF; dir_b[4] = 32'hFFFF_FFFF; dir_c[4] = 1'b0; dir_exp[4] = {1'b1, 32'hFFFF_FFFE};
        dir_a[5] = 32'hFFFF_FFFF; dir_b[5] = 32'hFFFF_FFFF; dir_c[5] = 1'b1; dir_exp[5] = {1'b1, 32'hFFFF_FFFF};
        dir_a[6] = 32'h0000_0001; dir_b[6] = 32'h7FFF_FFFF; dir_c[6] = 1'b0; dir_exp[6] = {1'b0, 32'h8000_0000};
        dir_a[7] = 32'h5555_5555; dir_b[7] = 32'hAAAA_AAAA; dir_c[7] = 1'b1; dir_exp[7] = {1'b1, 32'h0000_0000};
        dir_a[8] = 32'h0000_0000; dir_b[8] = 32'hFFFF_FFFF; dir_c[8] = 1'b0; dir_exp[8] = {1'b0, 32'hFFFF_FFFF};

        // Power-on reset with a carry-producing operand pair applied.
        rst_n = 1'b0;
        A     = 32'hFFFF_FFFF;
        B     = 32'h0000_0001;
        Cin   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hold", {Cout, S}, 33'h0);
        rst_n = 1'b1;
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 32'h0000_0000});

        for (int i = 0; i < 9; i++) drive(dir_a[i], dir_b[i], dir_c[i], dir_exp[i]);
        drain();

        // Inputs moving after the capture edge must not disturb the registered result.
        drive(32'h1234_5678, 32'h1111_1111, 1'b1, {1'b0, 32'h2345_678A});
        @(posedge clk);
        #2;
        A = 32'hFFFF_FFFF;
        B = 32'hFFFF_FFFF;
        #2;
        check("inputs_between_edges", {Cout, S}, {1'b0, 32'h2345_678A});
        drain();

        // Asynchronous reset mid-operation, asserted away from any clock edge.
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'hFFFF_FFFF});
        drain();
        @(posedge clk);
        #2;
        A     = 32'hFFFF_FFFF;
        B     = 32'h0000_0001;
        Cin   = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset", {Cout, S}, 33'h0);
        @(posedge clk);
        #1;
        check("reset_across_edge", {Cout, S}, 33'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 32'h0000_0000});

        // Random back-to-back traffic against the 33-bit reference sum.
        for (int i = 0; i < 1200; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(0, 1));
            if (i % 50 == 0) ra = 32'hFFFF_FFFF ^ rb;
            drive(ra, rb, rc, ref_add(ra, rb, rc));
        end
        drain();

        drive_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        if (!drive_done) begin
            $display("FAIL watchdog got timeout expected completion");
            $display("%0d/%0d checks passed", n_pass, n_checks + 1);
            $fatal(1, "watchdog expired");
        end
    end
endmodule
